spi_flash_cmd_engine: RTL and testbench

Fabric SPI master that executes complete serial-flash transactions: opcode, optional address, dummy cycles, then data. It generalises the fixed single-select MSS SPI_0 flash path with parameterised chip-select count, clock divider and transfer length. Read and write data move over valid/ready byte streams, so a UART command parser or a DMA block can drive it without CPU bit-banging. It sits in the fabric between the command layer and the flash pins.

---
 rtl/spi_flash_cmd_engine.sv | 197 +++++++++++++++++++
 tb/tb_spi_flash_cmd_engine.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_cmd_engine.sv
// rtl/spi_flash_cmd_engine.sv - SPI mode-0 flash master: opcode, address, dummy and data phases over byte streams
module spi_flash_cmd_engine #(
  parameter int NUM_CS     = 2,
  parameter int CS_W       = 3,
  parameter int CLK_DIV    = 2,
  parameter int LEN_W      = 16,
  parameter int CS_GAP_CYC = 4
) (
  input  logic              FAB_CCC_GL0,
  input  logic              FAB_RESET_N,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [7:0]        CMD_OPCODE,
  input  logic [31:0]       CMD_ADDR,
  input  logic [2:0]        CMD_ADDR_BYTES,
  input  logic [3:0]        CMD_DUMMY,
  input  logic [LEN_W-1:0]  CMD_LEN,
  input  logic              CMD_WRITE,
  input  logic [CS_W-1:0]   CMD_CS,
  input  logic [7:0]        WR_DATA,
  input  logic              WR_VALID,
  output logic              WR_READY,
  output logic [7:0]        RD_DATA,
  output logic              RD_VALID,
  input  logic              RD_READY,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic              SPI_CLK,
  output logic              SPI_DO,
  input  logic              SPI_DI,
  output logic [NUM_CS-1:0] SPI_SS_N
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (CS_GAP_CYC > 1) ? $clog2(CS_GAP_CYC) : 1;

  typedef enum logic [3:0] {
    IDLE, REJECT, CS_SETUP, OPCODE, ADDR, DUMMY, DATA, CS_HOLD, CS_GAP
  } state_t;

  state_t state, state_n, after_unit, after_addr, after_dummy;

  logic [31:0]       addr_q;
  logic [2:0]        ab_q;
  logic [3:0]        dummy_q;
  logic [LEN_W-1:0]  len_q, left;
  logic              wr_q;
  logic [DIV_W-1:0]  div_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        sh;
  logic [6:0]        rx;
  logic              sclk, byte_ready, rd_valid;
  logic [7:0]        rd_data;
  logic [NUM_CS-1:0] ss_n;
  logic              accept, bad_cmd, shift_st, running, tick, rise, fall, unit_end, rd_slot;

  function automatic logic [7:0] addr_byte(input logic [1:0] idx);
    return addr_q[{idx, 3'b000} +: 8];
  endfunction

  assign accept   = (state == IDLE) && CMD_VALID;
  assign bad_cmd  = ({1'b0, CMD_CS} >= (CS_W+1)'(NUM_CS)) || (CMD_ADDR_BYTES > 3'd4);
  assign shift_st = state inside {OPCODE, ADDR, DUMMY, DATA};
  assign rd_slot  = !rd_valid || RD_READY;
  // The DATA phase parks with SCLK low until the next byte (write) or a free read slot is available.
  assign running  = shift_st && !(state == DATA && !byte_ready);
  assign tick     = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise     = running && tick && !sclk;
  assign fall     = running && tick && sclk;
  assign unit_end = fall && (state == DUMMY || bit_cnt == 3'd7);

  assign CMD_READY = (state == IDLE);
  assign BUSY      = (state != IDLE);
  assign DONE      = (state == REJECT) || (state == CS_GAP && gap_cnt == '0);
  assign ERR       = (state == REJECT);
  assign WR_READY  = (state == DATA) && wr_q && !byte_ready && WR_VALID;
  assign SPI_CLK   = sclk;
  assign SPI_DO    = (state == OPCODE || state == ADDR || (state == DATA && wr_q && byte_ready)) ? sh[7] : 1'b0;
  assign SPI_SS_N  = ss_n;
  assign RD_DATA   = rd_data;
  assign RD_VALID  = rd_valid;

  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) state <= IDLE;
    else              state <= state_n;
  end

  always_comb begin
    state_n     = state;
    after_dummy = (len_q != '0) ? DATA : CS_HOLD;
    after_addr  = (dummy_q != 4'd0) ? DUMMY : after_dummy;
    after_unit  = CS_HOLD;
    case (state)
      OPCODE:  after_unit = (ab_q != 3'd0) ? ADDR : after_addr;
      ADDR:    after_unit = (left == LEN_W'(1)) ? after_addr : ADDR;
      DUMMY:   after_unit = (left == LEN_W'(1)) ? after_dummy : DUMMY;
      DATA:    after_unit = (left == LEN_W'(1)) ? CS_HOLD : DATA;
      default: after_unit = CS_HOLD;
    endcase
    case (state)
      IDLE:                       if (CMD_VALID) state_n = bad_cmd ? REJECT : CS_SETUP;
      REJECT:                     state_n = IDLE;
      CS_SETUP:                   if (tick) state_n = OPCODE;
      OPCODE, ADDR, DUMMY, DATA:  if (unit_end) state_n = after_unit;
      CS_HOLD:                    if (tick) state_n = CS_GAP;
      CS_GAP:                     if (gap_cnt == GAP_W'(CS_GAP_CYC - 1)) state_n = IDLE;
      default:                    state_n = IDLE;
    endcase
  end

  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      addr_q     <= '0;
      ab_q       <= '0;
      dummy_q    <= '0;
      len_q      <= '0;
      left       <= '0;
      wr_q       <= 1'b0;
      div_cnt    <= '0;
      gap_cnt    <= '0;
      bit_cnt    <= '0;
      sh         <= '0;
      rx         <= '0;
      sclk       <= 1'b0;
      byte_ready <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      ss_n       <= '1;
    end else begin
      if (accept) begin
        addr_q  <= CMD_ADDR;
        ab_q    <= CMD_ADDR_BYTES;
        dummy_q <= CMD_DUMMY;
        len_q   <= CMD_LEN;
        wr_q    <= CMD_WRITE;
        sh      <= CMD_OPCODE;
        bit_cnt <= '0;
      end

      if (accept && !bad_cmd)          ss_n <= ~(NUM_CS'(1) << CMD_CS);
      else if (state == CS_HOLD && tick) ss_n <= '1;

      if (state inside {CS_SETUP, CS_HOLD} || running) div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      else                                             div_cnt <= '0;

      gap_cnt <= (state == CS_GAP) ? gap_cnt + GAP_W'(1) : '0;

      if (!shift_st)           sclk <= 1'b0;
      else if (running && tick) sclk <= ~sclk;

      if (state == DATA && !byte_ready) begin
        if (wr_q && WR_VALID) begin
          sh         <= WR_DATA;
          byte_ready <= 1'b1;
        end else if (!wr_q && rd_slot) begin
          byte_ready <= 1'b1;
        end
      end

      if (rd_valid && RD_READY) rd_valid <= 1'b0;
      if (rise) begin
        rx <= {rx[5:0], SPI_DI};
        if (state == DATA && !wr_q && bit_cnt == 3'd7) begin
          rd_data  <= {rx, SPI_DI};
          rd_valid <= 1'b1;
        end
      end

      if (fall) begin
        if (unit_end) begin
          bit_cnt <= '0;
          case (state_n)
            ADDR: begin
              if (state == OPCODE) begin
                left <= LEN_W'(ab_q);
                sh   <= addr_byte(2'(ab_q - 3'd1));
              end else begin
                left <= left - LEN_W'(1);
                sh   <= addr_byte(2'(left - LEN_W'(2)));
              end
            end
            DUMMY: left <= (state == DUMMY) ? left - LEN_W'(1) : LEN_W'(dummy_q);
            DATA: begin
              left       <= (state == DATA) ? left - LEN_W'(1) : len_q;
              byte_ready <= 1'b0;
            end
            default: ;
          endcase
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
          sh      <= {sh[6:0], 1'b0};
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_flash_cmd_engine.sv
// tb/tb_spi_flash_cmd_engine.sv - directed bench for spi_flash_cmd_engine with a flash DI model and stream sinks
`timescale 1ns/1ps
module tb_spi_flash_cmd_engine;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_addr_bytes, cmd_cs;
  logic [3:0]  cmd_dummy;
  logic [15:0] cmd_len;
  logic [7:0]  wr_data, rd_data;
  logic        wr_valid, wr_ready, rd_valid, rd_ready;
  logic        busy, done, err, spi_clk, spi_do, spi_di;
  logic [1:0]  spi_ss_n;

  always #5 clk = ~clk;

  spi_flash_cmd_engine #(.NUM_CS(2), .CS_W(3), .CLK_DIV(2), .LEN_W(16), .CS_GAP_CYC(4)) dut (
    .FAB_CCC_GL0(clk), .FAB_RESET_N(rst_n),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_OPCODE(cmd_opcode), .CMD_ADDR(cmd_addr),
    .CMD_ADDR_BYTES(cmd_addr_bytes), .CMD_DUMMY(cmd_dummy), .CMD_LEN(cmd_len), .CMD_WRITE(cmd_write),
    .CMD_CS(cmd_cs), .WR_DATA(wr_data), .WR_VALID(wr_valid), .WR_READY(wr_ready),
    .RD_DATA(rd_data), .RD_VALID(rd_valid), .RD_READY(rd_ready),
    .BUSY(busy), .DONE(done), .ERR(err),
    .SPI_CLK(spi_clk), .SPI_DO(spi_do), .SPI_DI(spi_di), .SPI_SS_N(spi_ss_n)
  );

  int vectors = 0, miscompares = 0;
  int rise_cnt = 0, ss_bad = 0, ss_low_cyc = 0, wr_idx = 0, wr_pulses = 0, gap_left = 0;
  int di_base = 0, di_prefix = 0, di_n = 0, wr_end = 0, wr_gap_at = -1;
  logic        do_bits[$];
  logic [7:0]  rd_q[$];
  logic [7:0]  di_bytes[4];
  logic [7:0]  wr_bytes[4];
  logic [1:0]  exp_ss = 2'b11;

  // Flash model: each data bit is presented right after the previous SCLK rise, ready for the next one.
  always_comb begin
    int rel;
    rel = rise_cnt - di_base - di_prefix;
    spi_di = 1'b0;
    if (rel >= 0 && rel < 8 * di_n) spi_di = di_bytes[rel / 8][7 - (rel % 8)];
  end

  always @(posedge spi_clk) begin
    rise_cnt <= rise_cnt + 1;
    do_bits.push_back(spi_do);
    if (spi_ss_n !== exp_ss) ss_bad <= ss_bad + 1;
  end

  always @(posedge clk) begin
    if (spi_ss_n !== 2'b11) ss_low_cyc <= ss_low_cyc + 1;
    if (rd_valid && rd_ready) rd_q.push_back(rd_data);
    if (wr_ready) wr_pulses <= wr_pulses + 1;
    if (wr_valid && wr_ready) begin
      wr_idx <= wr_idx + 1;
      if (wr_idx + 1 == wr_gap_at) gap_left <= 80;
    end else if (gap_left > 0) begin
      gap_left <= gap_left - 1;
    end
  end

  always_comb begin
    wr_valid = (wr_idx < wr_end) && (gap_left == 0);
    wr_data  = wr_bytes[wr_idx[1:0]];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] do_byte(input int base, input int k);
    logic [7:0] b;
    for (int i = 0; i < 8; i++)
      b[7-i] = (base + 8*k + i < do_bits.size()) ? do_bits[base + 8*k + i] : 1'bx;
    return b;
  endfunction

  function automatic logic [7:0] rd_at(input int i);
    return (i < rd_q.size()) ? rd_q[i] : 8'hxx;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    check("idle_wait", cmd_ready, 1'b1);
  endtask

  task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [2:0] ab,
                       input logic [3:0] dm, input logic [15:0] len, input logic wr, input logic [2:0] cs);
    @(negedge clk);
    cmd_opcode = op; cmd_addr = addr; cmd_addr_bytes = ab; cmd_dummy = dm;
    cmd_len = len; cmd_write = wr; cmd_cs = cs; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_err"}, err, 1'b0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int rb, db, qb, sb, sl, r0, n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_addr = '0; cmd_addr_bytes = '0;
    cmd_dummy = '0; cmd_len = '0; cmd_write = 1'b0; cmd_cs = '0; rd_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ctrl", {cmd_ready, busy, done, err, wr_ready, rd_valid, spi_clk, spi_do}, 8'b1000_0000);
    check("reset_ss", spi_ss_n, 2'b11);
    check("reset_rd_data", rd_data, 8'h00);

    // Read ID on CS0
    exp_ss = 2'b10; di_bytes[0] = 8'hEF; di_bytes[1] = 8'h40; di_bytes[2] = 8'h18;
    di_n = 3; di_prefix = 8; di_base = rise_cnt;
    rb = rise_cnt; db = do_bits.size(); qb = rd_q.size(); sb = ss_bad;
    issue(8'h9F, 32'h0, 3'd0, 4'd0, 16'd3, 1'b0, 3'd0);
    check("rdid_busy", busy, 1'b1);
    wait_done("rdid");
    check("rdid_rises", rise_cnt - rb, 32);
    check("rdid_opcode", do_byte(db, 0), 8'h9F);
    check("rdid_do_quiet", {do_byte(db, 1), do_byte(db, 2), do_byte(db, 3)}, 24'h0);
    check("rdid_rd", {rd_at(qb), rd_at(qb+1), rd_at(qb+2)}, 24'hEF4018);
    check("rdid_rd_count", rd_q.size() - qb, 3);
    check("rdid_ss", ss_bad - sb, 0);
    wait_idle();

    // Fast read on CS1 with address and 8 dummy clocks
    exp_ss = 2'b01; di_bytes[0] = 8'hA5; di_bytes[1] = 8'h3C;
    di_n = 2; di_prefix = 40; di_base = rise_cnt;
    rb = rise_cnt; db = do_bits.size(); qb = rd_q.size(); sb = ss_bad;
    issue(8'h0B, 32'h0012_3456, 3'd3, 4'd8, 16'd2, 1'b0, 3'd1);
    wait_done("fread");
    check("fread_rises", rise_cnt - rb, 56);
    check("fread_hdr", {do_byte(db, 0), do_byte(db, 1), do_byte(db, 2), do_byte(db, 3)}, 32'h0B12_3456);
    check("fread_dummy_do", do_byte(db, 4), 8'h00);
    check("fread_rd", {rd_at(qb), rd_at(qb+1)}, 16'hA53C);
    check("fread_ss", ss_bad - sb, 0);
    wait_idle();

    // Page program with the third write byte held back
    exp_ss = 2'b10; di_n = 0;
    wr_bytes[0] = 8'hDE; wr_bytes[1] = 8'hAD; wr_bytes[2] = 8'hBE; wr_bytes[3] = 8'hEF;
    wr_gap_at = 2; wr_end = 4;
    rb = rise_cnt; db = do_bits.size(); sb = ss_bad; r0 = wr_pulses;
    issue(8'h02, 32'h0000_0100, 3'd3, 4'd0, 16'd4, 1'b1, 3'd0);
    n = 0;
    while (wr_idx < 2 && n < 5000) begin @(negedge clk); n++; end
    check("pp_reach_gap", wr_idx, 2);
    repeat (40) @(negedge clk);
    sl = rise_cnt;
    check("pp_gap_sclk", spi_clk, 1'b0);
    check("pp_gap_ss", spi_ss_n, 2'b10);
    repeat (5) @(negedge clk);
    check("pp_gap_stall", rise_cnt - sl, 0);
    wait_done("pp");
    check("pp_rises", rise_cnt - rb, 64);
    check("pp_hdr", {do_byte(db, 0), do_byte(db, 1), do_byte(db, 2), do_byte(db, 3)}, 32'h0200_0100);
    check("pp_data", {do_byte(db, 4), do_byte(db, 5), do_byte(db, 6), do_byte(db, 7)}, 32'hDEAD_BEEF);
    check("pp_wr_ready_pulses", wr_pulses - r0, 4);
    check("pp_ss", ss_bad - sb, 0);
    wait_idle();

    // Read with the consumer stalled on the first byte
    exp_ss = 2'b10; di_bytes[0] = 8'h11; di_bytes[1] = 8'h22; di_bytes[2] = 8'h33; di_bytes[3] = 8'h44;
    di_n = 4; di_prefix = 32; di_base = rise_cnt;
    rb = rise_cnt; qb = rd_q.size();
    rd_ready = 1'b0;
    issue(8'h03, 32'h0000_0000, 3'd3, 4'd0, 16'd4, 1'b0, 3'd0);
    n = 0;
    while (rd_valid !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    check("bp_first_valid", rd_valid, 1'b1);
    r0 = rise_cnt;
    repeat (30) @(negedge clk);
    check("bp_stall_rises", rise_cnt - r0, 0);
    check("bp_stall_sclk", spi_clk, 1'b0);
    check("bp_hold", {rd_valid, rd_data}, {1'b1, 8'h11});
    rd_ready = 1'b1;
    wait_done("bp");
    check("bp_rd", {rd_at(qb), rd_at(qb+1), rd_at(qb+2), rd_at(qb+3)}, 32'h1122_3344);
    check("bp_rises", rise_cnt - rb, 64);
    wait_idle();

    // Rejected commands: bad select, then bad address length
    sl = ss_low_cyc;
    issue(8'h9F, 32'h0, 3'd0, 4'd0, 16'd3, 1'b0, 3'd5);
    check("rej_cs_done_err", {done, err, busy}, 3'b111);
    @(negedge clk);
    check("rej_cs_after", {done, cmd_ready}, 2'b01);
    issue(8'h0B, 32'h0, 3'd6, 4'd0, 16'd1, 1'b0, 3'd0);
    check("rej_ab_done_err", {done, err, busy}, 3'b111);
    @(negedge clk);
    check("rej_ab_after", {done, cmd_ready}, 2'b01);
    check("rej_no_ss", ss_low_cyc - sl, 0);

    // Reset during the second data byte, then a clean transaction
    exp_ss = 2'b10; di_bytes[0] = 8'hAA; di_bytes[1] = 8'hBB; di_bytes[2] = 8'hCC;
    di_n = 3; di_prefix = 8; di_base = rise_cnt;
    rb = rise_cnt;
    issue(8'h9F, 32'h0, 3'd0, 4'd0, 16'd3, 1'b0, 3'd0);
    n = 0;
    while (rise_cnt - rb < 20 && n < 5000) begin @(negedge clk); n++; end
    check("rst_reach_byte2", rise_cnt - rb, 20);
    rst_n = 1'b0;
    #1;
    check("rst_async_pins", {spi_ss_n, spi_clk, spi_do}, 4'b1100);
    check("rst_async_ctrl", {busy, rd_valid, cmd_ready}, 3'b001);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_ready", {cmd_ready, busy}, 2'b10);
    exp_ss = 2'b01; di_bytes[0] = 8'h12; di_bytes[1] = 8'h34; di_bytes[2] = 8'h56;
    di_base = rise_cnt; rb = rise_cnt; qb = rd_q.size(); sb = ss_bad;
    issue(8'h9F, 32'h0, 3'd0, 4'd0, 16'd3, 1'b0, 3'd1);
    wait_done("post_rst");
    check("post_rst_rd", {rd_at(qb), rd_at(qb+1), rd_at(qb+2)}, 24'h123456);
    check("post_rst_rises", rise_cnt - rb, 32);
    check("post_rst_ss", ss_bad - sb, 0);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end
endmodule
